// File: rtl/cu_pkg.sv
// Shared control-unit definitions: control-word field positions, sequencer phase
// encoding and widths used by both the decoders and the sequencer.
package cu_pkg;

  localparam int CW_WIDTH     = 33;
  localparam int STATUS_WIDTH = 5;
  localparam int RETIRE_WIDTH = 32;
  localparam int CW_OUT_WIDTH = CW_WIDTH - 2;

  localparam int ALU_EN    = 32;
  localparam int ALU_BS    = 31;
  localparam int ALU_FS_HI = 30;
  localparam int ALU_FS_LO = 26;
  localparam int RF_B_EN   = 25;
  localparam int SA_HI     = 24;
  localparam int SA_LO     = 20;
  localparam int SB_HI     = 19;
  localparam int SB_LO     = 15;
  localparam int DA_HI     = 14;
  localparam int DA_LO     = 10;
  localparam int RF_W      = 9;
  localparam int RAM_EN    = 8;
  localparam int RAM_W     = 7;
  localparam int PC_EN     = 6;
  localparam int PC_FS_HI  = 5;
  localparam int PC_FS_LO  = 4;
  localparam int PC_IS     = 3;
  localparam int STATUS_LD = 2;
  localparam int NS_HI     = 1;
  localparam int NS_LO     = 0;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } phase_t;

  localparam logic [1:0] NEXT_FETCH = 2'b00;

  // Bits of cw_out (cw[32:2]) that must not take effect while a data access stalls.
  function automatic logic [CW_OUT_WIDTH-1:0] stall_mask();
    logic [CW_OUT_WIDTH-1:0] m;
    m = '0;
    m[RF_W - 2]      = 1'b1;
    m[RAM_W - 2]     = 1'b1;
    m[STATUS_LD - 2] = 1'b1;
    m[PC_FS_HI - 2]  = 1'b1;
    m[PC_FS_LO - 2]  = 1'b1;
    return m;
  endfunction

  localparam logic [CW_OUT_WIDTH-1:0] STALL_MASK = stall_mask();

endpackage

// File: rtl/cw_gate.sv
// Combinational masking of the decoder control word: whole word is killed outside
// EXEC, on illegal or reset; write-type fields are killed while stalled.
module cw_gate
  import cu_pkg::*;
(
  input  logic                    kill,
  input  phase_t                  phase,
  input  logic                    illegal,
  input  logic [CW_OUT_WIDTH-1:0] cw_fields,
  input  logic                    dmem_ready,
  output logic                    stall,
  output logic [CW_OUT_WIDTH-1:0] cw_out
);

  logic pass;

  assign pass  = ~kill & (phase == EXEC) & ~illegal;
  assign stall = cw_fields[RAM_EN - 2] & ~dmem_ready;

  generate
    for (genvar gi = 0; gi < CW_OUT_WIDTH; gi++) begin : g_bit
      assign cw_out[gi] = pass & cw_fields[gi] & ~(stall & STALL_MASK[gi]);
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: holds I, execute step and status for the decoders,
// then advances, stalls, retires or halts based on the selected control word.
module control_sequencer
  import cu_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req,
  input  logic                    imem_valid,
  input  logic [31:0]             imem_data,
  output logic [31:0]             I,
  output logic [1:0]              state,
  output logic [STATUS_WIDTH-1:0] status,
  input  logic [CW_WIDTH-1:0]     cw_in,
  input  logic                    illegal,
  input  logic [STATUS_WIDTH-1:0] alu_status,
  input  logic                    dmem_ready,
  output logic [CW_OUT_WIDTH-1:0] cw_out,
  output logic                    halted,
  output logic [RETIRE_WIDTH-1:0] retired
);

  phase_t                  phase_reg;
  logic [31:0]             i_reg;
  logic [1:0]              state_reg;
  logic [STATUS_WIDTH-1:0] status_reg;
  logic [RETIRE_WIDTH-1:0] retired_reg;
  logic                    stall;
  logic [1:0]              next_state;

  assign next_state = cw_in[NS_HI:NS_LO];

  cw_gate u_cw_gate (
    .kill       (reset),
    .phase      (phase_reg),
    .illegal    (illegal),
    .cw_fields  (cw_in[CW_WIDTH-1:2]),
    .dmem_ready (dmem_ready),
    .stall      (stall),
    .cw_out     (cw_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_reg   <= FETCH;
      i_reg       <= '0;
      state_reg   <= 2'b00;
      status_reg  <= '0;
      retired_reg <= '0;
    end else begin
      case (phase_reg)
        FETCH: begin
          if (imem_valid) begin
            i_reg     <= imem_data;
            state_reg <= 2'b00;
            phase_reg <= EXEC;
          end
        end
        EXEC: begin
          // illegal wins over stall, retire and status load
          if (illegal) begin
            phase_reg <= HALT;
          end else if (!stall) begin
            if (cw_in[STATUS_LD]) status_reg <= alu_status;
            if (next_state == NEXT_FETCH) begin
              retired_reg <= retired_reg + 1'b1;
              phase_reg   <= FETCH;
            end else begin
              state_reg <= next_state;
            end
          end
        end
        HALT:    phase_reg <= HALT;
        default: phase_reg <= FETCH;
      endcase
    end
  end

  assign imem_req = (phase_reg == FETCH) & ~reset;
  assign halted   = (phase_reg == HALT);
  assign I        = i_reg;
  assign state    = state_reg;
  assign status   = status_reg;
  assign retired  = retired_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed test of control_sequencer: fetch, multi-step execute, stall gating,
// status load, illegal halt and reset during a stall.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [31:0] I;
  logic [1:0]  state;
  logic [4:0]  status;
  logic [32:0] cw_in;
  logic        illegal;
  logic [4:0]  alu_status;
  logic        dmem_ready;
  logic [30:0] cw_out;
  logic        halted;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .I          (I),
    .state      (state),
    .status     (status),
    .cw_in      (cw_in),
    .illegal    (illegal),
    .alu_status (alu_status),
    .dmem_ready (dmem_ready),
    .cw_out     (cw_out),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_valid = 1'b1;
    imem_data  = word;
    tick();
    imem_valid = 1'b0;
    $display("txn fetch I=%h state=%0d", I, state);
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_valid = 1'b0; imem_data = '0; cw_in = 33'h1_FFFF_FFFF;
    illegal = 1'b0; alu_status = 5'b11111; dmem_ready = 1'b1;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %b exp 0", imem_req); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (I !== 32'h0) begin errors++; $display("FAIL reset_I got %h exp 0", I); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if (status !== 5'b0) begin errors++; $display("FAIL reset_status got %b exp 0", status); end
    checks++; if (retired !== 32'h0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired); end
    checks++; if (cw_out !== 31'h0) begin errors++; $display("FAIL reset_cw_out got %h exp 0", cw_out); end
    reset = 1'b0;
    #1;
    $display("txn reset released imem_req=%b", imem_req);
  endtask

  task automatic test_single();
    cw_in = 33'h200;  // rf_w=1, next_state=00
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL single_fetch_req got %b exp 1", imem_req); end
    checks++; if (cw_out !== 31'h0) begin errors++; $display("FAIL single_fetch_cw got %h exp 0", cw_out); end
    fetch(32'h8B020020);
    checks++; if (I !== 32'h8B020020) begin errors++; $display("FAIL single_I got %h exp 8b020020", I); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL single_exec_req got %b exp 0", imem_req); end
    checks++; if (cw_out !== 31'h80) begin errors++; $display("FAIL single_rf_w got %h exp 80", cw_out); end
    tick();
    checks++; if (cw_out !== 31'h0) begin errors++; $display("FAIL single_after_cw got %h exp 0", cw_out); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL single_after_req got %b exp 1", imem_req); end
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL single_retired got %0d exp 1", retired); end
    $display("txn single retired=%0d", retired);
  endtask

  task automatic test_fetch_wait();
    cw_in = 33'h200;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || cw_out !== 31'h0 || I !== 32'h8B020020) begin
        errors++; $display("FAIL wait_%0d got req=%b cw=%h I=%h exp req=1 cw=0 I=8b020020", k, imem_req, cw_out, I);
      end
      tick();
    end
    fetch(32'h12345678);
    checks++; if (I !== 32'h12345678) begin errors++; $display("FAIL wait_load_I got %h exp 12345678", I); end
    cw_in = 33'h0;
    tick();
    checks++; if (retired !== 32'd2) begin errors++; $display("FAIL wait_retired got %0d exp 2", retired); end
    $display("txn fetch_wait retired=%0d", retired);
  endtask

  task automatic test_multi();
    fetch(32'hA5A5_0001);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL multi_step0 got %b exp 00", state); end
    cw_in = 33'h1;
    tick();
    checks++; if (state !== 2'b01 || imem_req !== 1'b0) begin errors++; $display("FAIL multi_step1 got state=%b req=%b exp 01 0", state, imem_req); end
    cw_in = 33'h2;
    tick();
    checks++; if (state !== 2'b10 || retired !== 32'd2) begin errors++; $display("FAIL multi_step2 got state=%b ret=%0d exp 10 2", state, retired); end
    cw_in = 33'h0;
    tick();
    checks++; if (retired !== 32'd3 || imem_req !== 1'b1) begin errors++; $display("FAIL multi_retire got ret=%0d req=%b exp 3 1", retired, imem_req); end
    $display("txn multi retired=%0d", retired);
  endtask

  task automatic test_stall();
    fetch(32'h0000_00C3);
    cw_in = 33'h1B0;  // ram_en, ram_w, pc_fs=11, next_state=00
    dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (cw_out !== 31'h40 || state !== 2'b00 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_%0d got cw=%h state=%b req=%b exp 40 00 0", k, cw_out, state, imem_req);
      end
      tick();
    end
    checks++; if (retired !== 32'd3) begin errors++; $display("FAIL stall_no_retire got %0d exp 3", retired); end
    dmem_ready = 1'b1;
    #1;
    checks++; if (cw_out !== 31'h6C) begin errors++; $display("FAIL stall_release_cw got %h exp 6c", cw_out); end
    tick();
    checks++; if (retired !== 32'd4 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_retire got ret=%0d req=%b exp 4 1", retired, imem_req); end
    $display("txn stall retired=%0d", retired);
  endtask

  task automatic test_status();
    fetch(32'h0000_5555);
    cw_in = 33'h104;  // ram_en, status_ld
    alu_status = 5'b10010;
    dmem_ready = 1'b0;
    #1;
    checks++; if (cw_out !== 31'h40) begin errors++; $display("FAIL status_stall_cw got %h exp 40", cw_out); end
    tick();
    checks++; if (status !== 5'b00000) begin errors++; $display("FAIL status_stalled got %b exp 00000", status); end
    dmem_ready = 1'b1;
    #1;
    checks++; if (cw_out !== 31'h41) begin errors++; $display("FAIL status_go_cw got %h exp 41", cw_out); end
    tick();
    checks++; if (status !== 5'b10010 || retired !== 32'd5) begin errors++; $display("FAIL status_load got st=%b ret=%0d exp 10010 5", status, retired); end
    fetch(32'h0000_6666);
    cw_in = 33'h0;
    alu_status = 5'b00101;
    tick();
    checks++; if (status !== 5'b10010 || retired !== 32'd6) begin errors++; $display("FAIL status_hold got st=%b ret=%0d exp 10010 6", status, retired); end
    $display("txn status status=%b", status);
  endtask

  task automatic test_reset_mid_stall();
    fetch(32'h0000_7777);
    cw_in = 33'h106;  // ram_en, status_ld, next_state=10
    alu_status = 5'b01111;
    dmem_ready = 1'b0;
    tick();
    reset = 1'b1;
    dmem_ready = 1'b1;
    #1;
    checks++; if (cw_out !== 31'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_stall_cw got cw=%h req=%b exp 0 0", cw_out, imem_req); end
    tick();
    checks++; if (retired !== 32'd0 || state !== 2'b00 || status !== 5'b0 || I !== 32'h0) begin
      errors++; $display("FAIL rst_stall_state got ret=%0d st=%b status=%b I=%h exp 0 00 0 0", retired, state, status, I);
    end
    reset = 1'b0;
    cw_in = 33'h0;
    #1;
    checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL rst_stall_release got req=%b halt=%b exp 1 0", imem_req, halted); end
    $display("txn reset_mid_stall retired=%0d", retired);
  endtask

  task automatic test_illegal();
    fetch(32'h0000_1111);
    tick();  // cw_in=0: one retire
    illegal = 1'b1;
    cw_in = 33'h200;
    fetch(32'hDEAD_BEEF);  // illegal ignored during FETCH
    checks++; if (halted !== 1'b0 || I !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ill_fetch got halt=%b I=%h exp 0 deadbeef", halted, I); end
    checks++; if (cw_out !== 31'h0) begin errors++; $display("FAIL ill_exec_cw got %h exp 0", cw_out); end
    tick();
    illegal = 1'b0;
    imem_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (halted !== 1'b1 || cw_out !== 31'h0 || imem_req !== 1'b0 || retired !== 32'd1) begin
        errors++; $display("FAIL ill_halt_%0d got halt=%b cw=%h req=%b ret=%0d exp 1 0 0 1", k, halted, cw_out, imem_req, retired);
      end
      tick();
    end
    imem_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || retired !== 32'd0 || I !== 32'h0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL ill_reset got halt=%b ret=%0d I=%h req=%b exp 0 0 0 1", halted, retired, I, imem_req);
    end
    $display("txn illegal halted=%b", halted);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fetch_wait();
    test_multi();
    test_stall();
    test_status();
    test_reset_mid_stall();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
